// File: rtl/bsg_cgol_ctrl_if.sv
// Signal bundle between the Game-of-Life controller, the host row streams and the cell grid.
// The controller uses the master modport; the host/grid side uses the slave modport.
interface bsg_cgol_ctrl_if #(
    parameter int board_width_p     = 8,
    parameter int max_game_length_p = 255
);
    localparam int N  = board_width_p;
    localparam int FW = $clog2(max_game_length_p + 1);

    logic            valid_i;
    logic [N-1:0]    data_i;
    logic [FW-1:0]   frames_i;
    logic            ready_o;

    logic            en_o;
    logic [N*N-1:0]  update_o;
    logic [N*N-1:0]  update_val_o;
    logic [N*N-1:0]  cells_i;

    logic            valid_o;
    logic [N-1:0]    data_o;
    logic            ready_i;
    logic [FW-1:0]   gens_o;

    modport master (
        input  valid_i, data_i, frames_i, cells_i, ready_i,
        output ready_o, en_o, update_o, update_val_o, valid_o, data_o, gens_o
    );

    modport slave (
        output valid_i, data_i, frames_i, cells_i, ready_i,
        input  ready_o, en_o, update_o, update_val_o, valid_o, data_o, gens_o
    );
endinterface

// File: rtl/bsg_cgol_ctrl.sv
// Loads an N x N Game-of-Life board row by row, runs it for the requested generations, streams it back.
// Optional early exit on a still life is enabled by defining BSG_CGOL_CTRL_STILL_EXIT_EN.
module bsg_cgol_ctrl #(
    parameter int board_width_p     = 8,
    parameter int max_game_length_p = 255
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    bsg_cgol_ctrl_if.master bus
);
    localparam int N  = board_width_p;
    localparam int NN = N * N;
    localparam int FW = $clog2(max_game_length_p + 1);
    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_RUN    = 2'd1,
        S_UNLOAD = 2'd2
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic            r_started;
    logic [RW-1:0]   r_row_cnt;
    logic [FW-1:0]   r_gen_cnt;
    logic [FW-1:0]   r_frames;

    logic            w_ready;
    logic            w_valid;
    logic            w_en;
    logic            w_still;
    logic            w_load_fire;
    logic            w_unload_fire;
    logic            w_last_row;
    logic            w_run_done;
    logic [FW-1:0]   w_frames_eff;
    logic [FW-1:0]   w_gen_inc;
    logic [NN-1:0]   w_update;
    logic [NN-1:0]   w_update_val;
    logic [N-1:0]    w_rows [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rows
            assign w_rows[gi] = bus.cells_i[gi*N +: N];
        end
    endgenerate

    // ready_o is held low until the first clock after reset release
    assign w_ready       = (r_state == S_LOAD) && r_started;
    assign w_load_fire   = bus.valid_i && w_ready;
    assign w_unload_fire = w_valid && bus.ready_i;
    assign w_last_row    = (r_row_cnt == LAST_ROW);
    assign w_frames_eff  = (r_row_cnt == '0) ? bus.frames_i : r_frames;
    assign w_gen_inc     = r_gen_cnt + FW'(1);
    assign w_run_done    = (w_gen_inc == r_frames);

`ifdef BSG_CGOL_CTRL_STILL_EXIT_EN
    logic [NN-1:0] r_prev;

    assign w_still = (r_state == S_RUN) && (r_gen_cnt != '0) && (bus.cells_i == r_prev);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_prev <= '0;
        end else if (w_en) begin
            r_prev <= bus.cells_i;
        end
    end

    assign bus.gens_o = r_gen_cnt;
`else
    assign w_still    = 1'b0;
    assign bus.gens_o = '0;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_LOAD: begin
                if (w_load_fire && w_last_row) begin
                    w_state_next = (w_frames_eff == '0) ? S_UNLOAD : S_RUN;
                end
            end
            S_RUN: begin
                if (w_still || w_run_done) begin
                    w_state_next = S_UNLOAD;
                end
            end
            S_UNLOAD: begin
                if (w_unload_fire && w_last_row) begin
                    w_state_next = S_LOAD;
                end
            end
            default: w_state_next = S_LOAD;
        endcase
    end

    always_comb begin
        w_en         = 1'b0;
        w_valid      = 1'b0;
        w_update     = '0;
        w_update_val = '0;
        case (r_state)
            S_LOAD: begin
                for (int r = 0; r < N; r++) begin
                    if (w_load_fire && (int'(r_row_cnt) == r)) begin
                        w_update[r*N +: N]     = '1;
                        w_update_val[r*N +: N] = bus.data_i;
                    end
                end
            end
            S_RUN:    w_en    = !w_still;
            S_UNLOAD: w_valid = 1'b1;
            default: ;
        endcase
    end

    // row_cnt is shared: input row while loading, output row while unloading
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_started <= 1'b0;
            r_row_cnt <= '0;
            r_gen_cnt <= '0;
            r_frames  <= '0;
        end else begin
            r_started <= 1'b1;
            if (w_load_fire || w_unload_fire) begin
                r_row_cnt <= w_last_row ? '0 : r_row_cnt + RW'(1);
            end
            if (w_load_fire && (r_row_cnt == '0)) begin
                r_frames <= bus.frames_i;
            end
            if (w_en) begin
                r_gen_cnt <= w_gen_inc;
            end else if (w_unload_fire && w_last_row) begin
                r_gen_cnt <= '0;
            end
        end
    end

    assign bus.ready_o      = w_ready;
    assign bus.en_o         = w_en;
    assign bus.update_o     = w_update;
    assign bus.update_val_o = w_update_val;
    assign bus.valid_o      = w_valid;
    assign bus.data_o       = w_rows[r_row_cnt];

    a_no_en_with_update: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(w_en && (|w_update)));
    a_gen_bounded: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        r_gen_cnt <= r_frames);

endmodule

// File: tb/tb_bsg_cgol_ctrl.sv
// Self-checking bench for bsg_cgol_ctrl on a 4x4 board with a behavioural cell grid and board-level model.
module tb_bsg_cgol_ctrl;
    localparam int N  = 4;
    localparam int FW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bsg_cgol_ctrl_if #(.board_width_p(N), .max_game_length_p(15)) bus ();

    bsg_cgol_ctrl #(.board_width_p(N), .max_game_length_p(15)) dut (
        .clk_i    (clk),
        .reset_n_i(rst_n),
        .bus      (bus)
    );

    int checks   = 0;
    int failures = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // Life rule on a 4x4 board with dead cells beyond the edges; bit r*4+c is row r column c
    function automatic logic [15:0] life_step(input logic [15:0] b);
        logic [15:0] n;
        int cnt;
        n = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 4 && c + dc >= 0 && c + dc < 4)
                            cnt += int'(b[(r + dr) * 4 + c + dc]);
                    end
                end
                n[r*4 + c] = (cnt == 3) || (b[r*4 + c] && cnt == 2);
            end
        end
        return n;
    endfunction

    // Final board, generations applied and cycles from last load beat to first output beat
    function automatic void golden(input logic [15:0] b0, input int f,
                                   output logic [15:0] bf, output int g, output int lat);
        logic [15:0] b;
        logic [15:0] nb;
        int still;
        b = b0;
        g = 0;
        still = 0;
        while (g < f) begin
            nb = life_step(b);
            g++;
`ifdef BSG_CGOL_CTRL_STILL_EXIT_EN
            if (nb == b) begin
                if (g < f) still = 1;
                break;
            end
`endif
            b = nb;
        end
        bf  = b;
        lat = g + 1 + still;
    endfunction

    // Cell grid
    logic [15:0] grid = '0;
    assign bus.cells_i = grid;
    always @(posedge clk) begin
        if (|bus.update_o)
            grid <= (grid & ~bus.update_o) | (bus.update_val_o & bus.update_o);
        else if (bus.en_o)
            grid <= life_step(grid);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int m_up;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_up <= 0;
        else if (m_up < 2) m_up <= m_up + 1;
    end

    bit          m_busy = 1'b0;
    int          m_beats = 0;
    int          m_outi = 0;
    int          m_t = 0;
    int          m_g = 0;
    int          m_lat = 0;
    int          m_f = 0;
    logic [15:0] m_board = '0;
    logic [15:0] m_exp = '0;
    int          en_count = 0;
    int          hs_count = 0;
    int          boards_done = 0;
    logic [15:0] upd_log [4];
    logic [3:0]  out_log [4];
    logic [3:0]  gens_log = '0;
    bit          prev_valid = 1'b0;
    bit          prev_ready = 1'b0;
    logic [3:0]  prev_data = '0;

    always @(negedge clk) begin : cmp
        logic        fire;
        logic [15:0] exp_upd;
        bit          exp_en;
        bit          exp_valid;
        if (!rst_n) begin
            check("rst_ready", 32'(bus.ready_o), 32'(0));
            check("rst_update", 32'(bus.update_o), 32'(0));
            check("rst_en", 32'(bus.en_o), 32'(0));
            check("rst_valid", 32'(bus.valid_o), 32'(0));
            m_busy = 1'b0; m_beats = 0; m_outi = 0; prev_valid = 1'b0;
        end else begin
            check("ready", 32'(bus.ready_o), 32'(m_up >= 1 && !m_busy));
            fire    = bus.valid_i && bus.ready_o;
            exp_upd = fire ? (16'hF << (4 * m_beats)) : 16'h0;
            check("update", 32'(bus.update_o), 32'(exp_upd));
            if (fire) check("update_val_row", 32'(bus.update_val_o[4*m_beats +: 4]), 32'(bus.data_i));
            exp_en = m_busy && (cyc > m_t) && (cyc <= m_t + m_g);
            check("en", 32'(bus.en_o), 32'(exp_en));
            exp_valid = m_busy && (cyc >= m_t + m_lat);
            check("valid", 32'(bus.valid_o), 32'(exp_valid));
            if (prev_valid && !prev_ready) check("stall_data", 32'(bus.data_o), 32'(prev_data));
            if (bus.valid_o) begin
                check("data", 32'(bus.data_o), 32'(m_exp[4*m_outi +: 4]));
`ifdef BSG_CGOL_CTRL_STILL_EXIT_EN
                check("gens", 32'(bus.gens_o), 32'(m_g));
`else
                check("gens", 32'(bus.gens_o), 32'(0));
`endif
            end
            if (bus.en_o) en_count++;
            if (fire) begin
                upd_log[m_beats] = bus.update_o;
                m_board[4*m_beats +: 4] = bus.data_i;
                if (m_beats == 0) m_f = int'(bus.frames_i);
                m_beats++;
                if (m_beats == 4) begin
                    golden(m_board, m_f, m_exp, m_g, m_lat);
                    m_busy = 1'b1; m_t = cyc; m_outi = 0; m_beats = 0;
                end
            end
            if (bus.valid_o && bus.ready_i) begin
                out_log[m_outi] = bus.data_o;
                if (m_outi == 0) gens_log = bus.gens_o;
                hs_count++;
                m_outi++;
                if (m_outi == 4) begin
                    m_busy = 1'b0; m_outi = 0; boards_done++;
                end
            end
            prev_valid = bus.valid_o;
            prev_ready = bus.ready_i;
            prev_data  = bus.data_o;
        end
    end

    task automatic load_board(input logic [15:0] b, input logic [3:0] f);
        bit got;
        en_count = 0;
        for (int r = 0; r < 4; r++) begin
            bus.valid_i  = 1'b1;
            bus.data_i   = b[4*r +: 4];
            bus.frames_i = (r == 0) ? f : ~f;
            got = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (bus.ready_o) begin got = 1'b1; break; end
            end
            check("load_timeout", 32'(got), 32'(1));
            @(posedge clk); #1;
        end
        bus.valid_i = 1'b0;
    endtask

    task automatic wait_out(input logic [3:0] pat);
        int start;
        int sel;
        bit done;
        start = boards_done; sel = 0; done = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (boards_done != start) begin done = 1'b1; break; end
            if (bus.valid_o) begin
                bus.ready_i = pat[sel];
                sel = (sel + 1) % 4;
            end else begin
                bus.ready_i = 1'b0;
            end
            @(posedge clk); #1;
        end
        check("unload_timeout", 32'(done), 32'(1));
        bus.ready_i = 1'b1;
    endtask

    task automatic check_rows(input string tag, input logic [15:0] exp);
        for (int r = 0; r < 4; r++)
            check($sformatf("%s_row%0d", tag, r), 32'(out_log[r]), 32'(exp[4*r +: 4]));
    endtask

    initial begin
        int hs_before;
        bit seen;
        bus.valid_i = 1'b1; bus.data_i = 4'hF; bus.frames_i = '0; bus.ready_i = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready_lit", 32'(bus.ready_o), 32'(0));
        check("rst_update_lit", 32'(bus.update_o), 32'(0));
        bus.valid_i = 1'b0;
        rst_n = 1'b1;
        #1;
        check("ready_before_first_clk", 32'(bus.ready_o), 32'(0));
        @(posedge clk); #1;
        check("ready_after_first_clk", 32'(bus.ready_o), 32'(1));

        check("life_blinker_v2h", 32'(life_step(16'h0222)), 32'h0070);
        check("life_blinker_h2v", 32'(life_step(16'h0070)), 32'h0222);
        check("life_block", 32'(life_step(16'h0660)), 32'h0660);

        // Block, F=0
        load_board(16'h0660, 4'd0);
        wait_out(4'b1111);
        check("A_upd0", 32'(upd_log[0]), 32'h000F);
        check("A_upd1", 32'(upd_log[1]), 32'h00F0);
        check("A_upd2", 32'(upd_log[2]), 32'h0F00);
        check("A_upd3", 32'(upd_log[3]), 32'hF000);
        check("A_en_count", 32'(en_count), 32'(0));
        check_rows("A_out", 16'h0660);

        // Block, F=5, with valid_i asserted while running
        load_board(16'h0660, 4'd5);
        bus.valid_i = 1'b1; bus.data_i = 4'h9;
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (bus.valid_o) begin seen = 1'b1; break; end
        end
        bus.valid_i = 1'b0;
        check("B_valid_seen", 32'(seen), 32'(1));
        wait_out(4'b1111);
`ifdef BSG_CGOL_CTRL_STILL_EXIT_EN
        check("B_en_count", 32'(en_count), 32'(1));
        check("B_gens", 32'(gens_log), 32'(1));
`else
        check("B_en_count", 32'(en_count), 32'(5));
        check("B_gens", 32'(gens_log), 32'(0));
`endif
        check_rows("B_out", 16'h0660);

        // Vertical blinker, F=1
        load_board(16'h0222, 4'd1);
        wait_out(4'b1111);
        check_rows("C_out", 16'h0070);
        check("C_en_count", 32'(en_count), 32'(1));

        // Vertical blinker, F=2, with stalled output
        load_board(16'h0222, 4'd2);
        hs_before = hs_count;
        wait_out(4'b1001);
        check("D_ready_after", 32'(bus.ready_o), 32'(1));
        check("D_beats", 32'(hs_count - hs_before), 32'(4));
        check_rows("D_out", 16'h0222);

        // Reset during RUN cycle 3 of F=10
        load_board(16'h0222, 4'd10);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("E_run_cycle3_en", 32'(bus.en_o), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check("E_async_en_clear", 32'(bus.en_o), 32'(0));
        check("E_async_ready_clear", 32'(bus.ready_o), 32'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("E_ready_after_reset", 32'(bus.ready_o), 32'(1));

        load_board(16'h0222, 4'd1);
        wait_out(4'b1111);
        check_rows("F_out", 16'h0070);
        check("F_en_count", 32'(en_count), 32'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
